spi_ram_ctrl: RTL and testbench

Command-decoding RAM controller that sits directly downstream of the SPI slave. It consumes the slave's 10-bit received words (`rx_data`/`rx_valid`) as write-address, write-data, read-address and read-data commands against an internal single-port memory. It returns read data to the slave's transmit side on `tx_data`/`tx_valid`, holding `tx_valid` long enough for the slave to shift all 8 bits out on MISO.

---
 rtl/spi_ram_ctrl.sv | 107 ++++++++++
 tb/tb_spi_ram_ctrl.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/spi_ram_ctrl.sv
// Command-decoding RAM controller downstream of an SPI slave: decodes 10-bit words into
// address/data/read commands on a single-port memory. Optional `SPI_RAM_AUTOINC_EN` auto-increments addresses.
module spi_ram_ctrl #(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_SIZE = 8,
  parameter int TX_HOLD   = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] din,
  input  logic       rx_valid,
  output logic [7:0] dout,
  output logic       tx_valid
);

  // Handshake: a command is taken only on the first edge where rx_valid is seen high after
  // being low; tx_valid is a level held for TX_HOLD cycles per read, restarted by a new read.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    TX   = 2'd2
  } state_t;

  localparam logic [3:0]           HOLD_LAST = 4'(TX_HOLD);
  localparam logic [ADDR_SIZE-1:0] ADDR_ONE  = ADDR_SIZE'(1);

  state_t               state;
  logic [7:0]           mem [MEM_DEPTH];
  logic [ADDR_SIZE-1:0] wr_addr;
  logic [ADDR_SIZE-1:0] rd_addr;
  logic                 rx_valid_q;
  logic [3:0]           hold_cnt;
  logic [1:0]           opcode;
  logic                 accept;

  assign opcode = din[9:8];
  assign accept = rx_valid & ~rx_valid_q;

  // Memory has no reset so its contents survive rst_n.
  always_ff @(posedge clk) begin
    if (accept && opcode == 2'b01) begin
      mem[wr_addr] <= din[7:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      dout       <= 8'h00;
      tx_valid   <= 1'b0;
      wr_addr    <= '0;
      rd_addr    <= '0;
      rx_valid_q <= 1'b0;
      hold_cnt   <= 4'd0;
    end else begin
      rx_valid_q <= rx_valid;

      if (accept && opcode == 2'b00) begin
        wr_addr <= din[ADDR_SIZE-1:0];
      end
`ifdef SPI_RAM_AUTOINC_EN
      else if (accept && opcode == 2'b01) begin
        wr_addr <= wr_addr + ADDR_ONE;
      end
`endif

      // An explicit address load wins over the post-read increment.
      if (accept && opcode == 2'b10) begin
        rd_addr <= din[ADDR_SIZE-1:0];
      end
`ifdef SPI_RAM_AUTOINC_EN
      else if (state == READ) begin
        rd_addr <= rd_addr + ADDR_ONE;
      end
`endif

      case (state)
        IDLE: begin
          if (accept && opcode == 2'b11) begin
            state <= READ;
          end
        end
        READ: begin
          dout     <= mem[rd_addr];
          tx_valid <= 1'b1;
          hold_cnt <= 4'd1;
          state    <= TX;
        end
        TX: begin
          if (accept && opcode == 2'b11) begin
            state <= READ;
          end else if (hold_cnt == HOLD_LAST) begin
            tx_valid <= 1'b0;
            hold_cnt <= 4'd0;
            state    <= IDLE;
          end else begin
            hold_cnt <= hold_cnt + 4'd1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_ram_ctrl.sv
// Directed bench for spi_ram_ctrl: stimulus pushes expected read data and tx_valid run
// lengths into queues; a negedge monitor pops and compares as the DUT presents them.
module tb_spi_ram_ctrl;

  localparam int TX_HOLD = 10;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] din;
  logic       rx_valid;
  logic [7:0] dout;
  logic       tx_valid;

  int tests = 0;
  int fails = 0;

  logic [7:0] exp_q[$];
  int         len_q[$];

  spi_ram_ctrl #(
    .MEM_DEPTH(256),
    .ADDR_SIZE(8),
    .TX_HOLD  (TX_HOLD)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .din     (din),
    .rx_valid(rx_valid),
    .dout    (dout),
    .tx_valid(tx_valid)
  );

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Driver tasks
  task automatic send_cmd(input logic [9:0] cmd);
    @(posedge clk);
    #1;
    din      = cmd;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    repeat (2) @(posedge clk);
    #1;
    while (tx_valid && n < 60) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("idle_timeout", {31'b0, tx_valid}, 32'd0);
  endtask

  // Scoreboard monitor
  logic       prev_v = 1'b0;
  logic [7:0] prev_d = 8'h00;
  int         run    = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_v = 1'b0;
      prev_d = 8'h00;
      run    = 0;
    end else begin
      if (tx_valid && (!prev_v || dout !== prev_d)) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_read: dout=0x%0h, expected no new read data", dout);
        end else begin
          check("read_data", {24'b0, dout}, {24'b0, exp_q.pop_front()});
        end
      end
      if (tx_valid) begin
        run++;
      end else if (prev_v) begin
        if (len_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_tx_run: length=%0d, expected no tx_valid pulse", run);
        end else begin
          check("tx_hold_len", run, len_q.pop_front());
        end
        run = 0;
      end
      prev_v = tx_valid;
      prev_d = dout;
    end
  end

  // Stimulus
  initial begin
    rst_n    = 1'b0;
    rx_valid = 1'b0;
    din      = 10'h000;
    repeat (3) @(posedge clk);
    #1;
    check("rst_dout", {24'b0, dout}, 32'h00);
    check("rst_tx_valid", {31'b0, tx_valid}, 32'd0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("idle_tx_valid", {31'b0, tx_valid}, 32'd0);
    check("idle_dout", {24'b0, dout}, 32'h00);

    // Basic write then read, with latency probes
    send_cmd(10'h012);
    send_cmd(10'h1A5);
    send_cmd(10'h212);
    exp_q.push_back(8'hA5);
    len_q.push_back(TX_HOLD);
    send_cmd(10'h300);
    check("read_lat_accept_edge", {31'b0, tx_valid}, 32'd0);
    @(posedge clk);
    #1;
    check("read_lat_valid", {31'b0, tx_valid}, 32'd1);
    check("read_lat_dout", {24'b0, dout}, 32'hA5);
    wait_idle();
    check("dout_hold_after_tx", {24'b0, dout}, 32'hA5);

    // Level held high: only the first edge writes, later din changes are ignored
    send_cmd(10'h040);
    @(posedge clk);
    #1;
    din      = 10'h1FF;
    rx_valid = 1'b1;
    repeat (10) @(posedge clk);
    #1 din = 10'h100;
    repeat (10) @(posedge clk);
    #1 rx_valid = 1'b0;
    send_cmd(10'h240);
    exp_q.push_back(8'hFF);
    len_q.push_back(TX_HOLD);
    send_cmd(10'h300);
    wait_idle();

    // Second read issued during TX: tx_valid stays high, hold restarts
    send_cmd(10'h034);
    send_cmd(10'h15C);
    send_cmd(10'h212);
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h5C);
    len_q.push_back(TX_HOLD + 4);
    send_cmd(10'h300);
    send_cmd(10'h234);
    send_cmd(10'h300);
    check("retrig_tx_held", {31'b0, tx_valid}, 32'd1);
    check("retrig_old_dout", {24'b0, dout}, 32'hA5);
    @(posedge clk);
    #1;
    check("retrig_new_dout", {24'b0, dout}, 32'h5C);
    check("retrig_new_valid", {31'b0, tx_valid}, 32'd1);
    wait_idle();

    // Reset on the 4th TX cycle, then memory retention
    send_cmd(10'h234);
    exp_q.push_back(8'h5C);
    send_cmd(10'h300);
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_tx_valid", {31'b0, tx_valid}, 32'd0);
    check("rst_mid_dout", {24'b0, dout}, 32'h00);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1 rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("post_rst_quiet", {31'b0, tx_valid}, 32'd0);
    send_cmd(10'h212);
    exp_q.push_back(8'hA5);
    len_q.push_back(TX_HOLD);
    send_cmd(10'h300);
    wait_idle();

    // Address wrap / auto-increment
    send_cmd(10'h0FF);
    send_cmd(10'h111);
    send_cmd(10'h122);
    send_cmd(10'h2FF);
`ifdef SPI_RAM_AUTOINC_EN
    exp_q.push_back(8'h11);
`else
    exp_q.push_back(8'h22);
`endif
    len_q.push_back(TX_HOLD);
    send_cmd(10'h300);
    wait_idle();
    exp_q.push_back(8'h22);
    len_q.push_back(TX_HOLD);
    send_cmd(10'h300);
    wait_idle();

    // Final report
    repeat (3) @(posedge clk);
    #1;
    check("exp_q_drained", exp_q.size(), 32'd0);
    check("len_q_drained", len_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
